// File: rtl/leaf_stream_router.sv
// BFT leaf router: demultiplexes inbound packets into per-input FIFOs and
// route/credit tables, then merges credit-gated user outputs round-robin.
module leaf_stream_router #(
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_LEAF_BITS = 5,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_ADDR_BITS = 7,
  parameter int PACKET_BITS   = 1 + NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS + PAYLOAD_BITS,
  parameter int NUM_IN_PORTS  = 4,
  parameter int NUM_OUT_PORTS = 3,
  parameter int FIFO_DEPTH    = 16,
  parameter int INIT_CREDITS  = 64
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [PACKET_BITS-1:0]                  din_leaf_bft2interface,
  output logic [PACKET_BITS-1:0]                  dout_leaf_interface2bft,
  input  logic                                    resend,
  output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]    dout_leaf_interface2user,
  output logic [NUM_IN_PORTS-1:0]                 vld_interface2user,
  input  logic [NUM_IN_PORTS-1:0]                 ack_user2interface,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   din_leaf_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]                vld_user2interface,
  output logic [NUM_OUT_PORTS-1:0]                ack_interface2user,
  output logic [NUM_IN_PORTS-1:0]                 overflow
);

  localparam int ROUTE_W = NUM_LEAF_BITS + NUM_PORT_BITS;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int CRED_W  = $clog2(INIT_CREDITS) + 8;
  localparam int SUM_W   = ((PAYLOAD_BITS > CRED_W) ? PAYLOAD_BITS : CRED_W) + 1;
  localparam int IDX_W   = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
  localparam logic [CRED_W-1:0] CRED_MAX = '1;

  // ---------------------------------------------------------------- decode
  logic                     pkt_vld;
  logic [NUM_PORT_BITS-1:0] pkt_port;
  logic [NUM_ADDR_BITS-1:0] pkt_addr;
  logic [PAYLOAD_BITS-1:0]  pkt_payload;
  logic                     cfg_wr;
  logic                     cred_wr;
  logic                     unused_leaf;

  assign pkt_vld     = din_leaf_bft2interface[PACKET_BITS-1];
  assign pkt_port    = din_leaf_bft2interface[PAYLOAD_BITS+NUM_ADDR_BITS +: NUM_PORT_BITS];
  assign pkt_addr    = din_leaf_bft2interface[PAYLOAD_BITS +: NUM_ADDR_BITS];
  assign pkt_payload = din_leaf_bft2interface[PAYLOAD_BITS-1:0];
  // The inbound leaf field names this leaf itself, so it carries no routing information here.
  assign unused_leaf = ^din_leaf_bft2interface[PACKET_BITS-2 -: NUM_LEAF_BITS];

  assign cfg_wr  = pkt_vld && (pkt_port == '0);
  assign cred_wr = pkt_vld && (pkt_port == NUM_PORT_BITS'(1));

  // ----------------------------------------------------------- input FIFOs
  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN_PORTS; gi++) begin : g_fifo
      logic [PAYLOAD_BITS-1:0] mem_q [FIFO_DEPTH];
      logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
      logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
      logic [CNT_W-1:0]        count_q, count_d;
      logic                    ovf_q, ovf_d;
      logic                    push_req, full, pop, push;

      assign push_req = pkt_vld && (32'(pkt_port) == gi + 2);
      assign full     = (count_q == CNT_W'(FIFO_DEPTH));
      assign pop      = (count_q != '0) && ack_user2interface[gi];
      // A full FIFO still accepts a push when its head leaves in the same cycle.
      assign push     = push_req && (!full || pop);

      always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        ovf_d    = ovf_q | (push_req & full & ~pop);
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          count_q  <= '0;
          ovf_q    <= 1'b0;
        end else begin
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
          count_q  <= count_d;
          ovf_q    <= ovf_d;
        end
      end

      always_ff @(posedge clk) begin
        if (push) begin
          mem_q[wr_ptr_q] <= pkt_payload;
        end
      end

      assign vld_interface2user[gi] = (count_q != '0);
      assign dout_leaf_interface2user[gi*PAYLOAD_BITS +: PAYLOAD_BITS] = mem_q[rd_ptr_q];
      assign overflow[gi] = ovf_q;
    end
  endgenerate

  // ------------------------------------------------- route and credit state
  logic [ROUTE_W-1:0]       route_q  [NUM_OUT_PORTS];
  logic [ROUTE_W-1:0]       route_d  [NUM_OUT_PORTS];
  logic [CRED_W-1:0]        credit_q [NUM_OUT_PORTS];
  logic [CRED_W-1:0]        credit_d [NUM_OUT_PORTS];
  logic [NUM_OUT_PORTS-1:0] eligible;
  logic [NUM_OUT_PORTS-1:0] grant;
  logic                     grant_any;
  logic [IDX_W-1:0]         grant_idx;
  logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [PACKET_BITS-1:0]   dout_q, dout_d;

  always_comb begin : credit_route_next
    logic [SUM_W-1:0] sum;
    sum = '0;
    for (int o = 0; o < NUM_OUT_PORTS; o++) begin
      route_d[o] = route_q[o];
      if (cfg_wr && (32'(pkt_addr) == o)) begin
        route_d[o] = pkt_payload[ROUTE_W-1:0];
      end
      // Grant only happens with credit != 0, so the subtraction never underflows.
      sum = SUM_W'(credit_q[o]) - SUM_W'(grant[o]);
      if (cred_wr && (32'(pkt_addr) == o)) begin
        sum = sum + SUM_W'(pkt_payload);
      end
      credit_d[o] = (sum > SUM_W'(CRED_MAX)) ? CRED_MAX : CRED_W'(sum);
    end
  end

  always_comb begin
    for (int o = 0; o < NUM_OUT_PORTS; o++) begin
      eligible[o] = vld_user2interface[o] && (credit_q[o] != '0);
    end
  end

  // ------------------------------------------------------------- arbiter
  always_comb begin : arbiter
    int idx;
    idx       = 0;
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    if (!reset && !resend) begin
      for (int k = 0; k < NUM_OUT_PORTS; k++) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= NUM_OUT_PORTS) begin
          idx = idx - NUM_OUT_PORTS;
        end
        if (!grant_any && eligible[idx]) begin
          grant_any  = 1'b1;
          grant_idx  = IDX_W'(idx);
          grant[idx] = 1'b1;
        end
      end
    end
  end

  assign ack_interface2user = grant;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_any) begin
      rr_ptr_d = (32'(grant_idx) == NUM_OUT_PORTS - 1) ? '0 : grant_idx + IDX_W'(1);
    end
  end

  always_comb begin
    dout_d = '0;
    if (resend) begin
      dout_d = dout_q;
    end else if (grant_any) begin
      dout_d = {1'b1, route_q[grant_idx], NUM_ADDR_BITS'(grant_idx),
                din_leaf_user2interface[32'(grant_idx)*PAYLOAD_BITS +: PAYLOAD_BITS]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q   <= '0;
      rr_ptr_q <= '0;
      for (int o = 0; o < NUM_OUT_PORTS; o++) begin
        route_q[o]  <= '0;
        credit_q[o] <= CRED_W'(INIT_CREDITS);
      end
    end else begin
      dout_q   <= dout_d;
      rr_ptr_q <= rr_ptr_d;
      for (int o = 0; o < NUM_OUT_PORTS; o++) begin
        route_q[o]  <= route_d[o];
        credit_q[o] <= credit_d[o];
      end
    end
  end

  assign dout_leaf_interface2bft = dout_q;

endmodule

// File: tb/tb_leaf_stream_router.sv
// Scoreboard bench for leaf_stream_router: stimulus pushes expected words and
// packets into queues, monitors pop and compare on each user pop / new BFT packet.
module tb_leaf_stream_router;

  localparam int PAY    = 32;
  localparam int LEAF_W = 5;
  localparam int PORT_W = 4;
  localparam int ADDR_W = 7;
  localparam int PKT    = 1 + LEAF_W + PORT_W + ADDR_W + PAY;
  localparam int NI     = 4;
  localparam int NO     = 3;
  localparam int DEPTH  = 16;
  localparam int INIT   = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [PKT-1:0]    din_bft = '0;
  logic [PKT-1:0]    dout_bft;
  logic              resend = 1'b0;
  logic [NI*PAY-1:0] dout_user;
  logic [NI-1:0]     vld_out;
  logic [NI-1:0]     ack_in = '0;
  logic [NO*PAY-1:0] din_user = '0;
  logic [NO-1:0]     vld_user = '0;
  logic [NO-1:0]     ack_out;
  logic [NI-1:0]     ovf;

  always #5 clk = ~clk;

  leaf_stream_router #(
    .PAYLOAD_BITS(PAY), .NUM_LEAF_BITS(LEAF_W), .NUM_PORT_BITS(PORT_W),
    .NUM_ADDR_BITS(ADDR_W), .PACKET_BITS(PKT), .NUM_IN_PORTS(NI),
    .NUM_OUT_PORTS(NO), .FIFO_DEPTH(DEPTH), .INIT_CREDITS(INIT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .din_leaf_bft2interface(din_bft),
    .dout_leaf_interface2bft(dout_bft),
    .resend(resend),
    .dout_leaf_interface2user(dout_user),
    .vld_interface2user(vld_out),
    .ack_user2interface(ack_in),
    .din_leaf_user2interface(din_user),
    .vld_user2interface(vld_user),
    .ack_interface2user(ack_out),
    .overflow(ovf)
  );

  int             checks = 0;
  int             failures = 0;
  logic [PAY-1:0] exp_in [NI][$];
  logic [PKT-1:0] exp_bft [$];
  int             words_left [NO] = '{default: 0};
  int             sent [NO] = '{default: 0};
  logic [PAY-1:0] base [NO] = '{default: '0};
  logic [NO-1:0]  ack_seen = '0;
  logic           resend_prev = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [PKT-1:0] mk(input int leaf, input int port, input int addr,
                                        input logic [PAY-1:0] pay);
    return {1'b1, LEAF_W'(leaf), PORT_W'(port), ADDR_W'(addr), pay};
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input int port, input int addr, input logic [PAY-1:0] pay);
    din_bft = mk(0, port, addr, pay);
    cycle();
    din_bft = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    resend = 1'b0;
    din_bft = '0;
    ack_in = '0;
    for (int i = 0; i < NO; i++) words_left[i] = 0;
    cycle();
    cycle();
    for (int i = 0; i < NO; i++) sent[i] = 0;
    for (int i = 0; i < NI; i++) exp_in[i].delete();
    exp_bft.delete();
    reset = 1'b0;
  endtask

  task automatic drain(input int i, input string name);
    ack_in[i] = 1'b1;
    for (int n = 0; n < 40 && vld_out[i]; n++) cycle();
    ack_in[i] = 1'b0;
    chk(name, {63'd0, vld_out[i]}, 64'd0);
    chk({name, "_sb"}, 64'(exp_in[i].size()), 64'd0);
  endtask

  // User-side output drivers: each output sends words_left words, payload base+index.
  always @(negedge clk) ack_seen = ack_out;
  always begin
    @(posedge clk);
    #3;
    for (int i = 0; i < NO; i++) begin
      if (ack_seen[i] && words_left[i] > 0) begin
        words_left[i]--;
        sent[i]++;
      end
      vld_user[i] = (words_left[i] > 0);
      din_user[i*PAY +: PAY] = base[i] + PAY'(sent[i]);
    end
  end

  always @(posedge clk) resend_prev = resend;

  // Monitor: a user pop or a freshly launched BFT packet consumes one expectation.
  always @(negedge clk) begin
    logic [PAY-1:0] e;
    logic [PKT-1:0] ep;
    for (int i = 0; i < NI; i++) begin
      if (vld_out[i] && ack_in[i]) begin
        if (exp_in[i].size() == 0) begin
          chk($sformatf("in%0d_unexpected_pop", i), 64'(dout_user[i*PAY +: PAY]), 64'hDEAD_0000_0000);
        end else begin
          e = exp_in[i].pop_front();
          chk($sformatf("in%0d_data", i), 64'(dout_user[i*PAY +: PAY]), 64'(e));
        end
      end
    end
    if (!reset && dout_bft[PKT-1] && !resend_prev) begin
      if (exp_bft.size() == 0) begin
        chk("bft_unexpected_pkt", 64'(dout_bft), 64'd0);
      end else begin
        ep = exp_bft.pop_front();
        chk("bft_pkt", 64'(dout_bft), 64'(ep));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int             ord4 [6] = '{0, 1, 2, 0, 1, 2};
    int             ord5 [10] = '{0, 1, 2, 0, 1, 2, 1, 2, 1, 2};
    int             cnt [NO];
    logic [PKT-1:0] snap;

    // Reset state
    do_reset();
    chk("rst_dout", 64'(dout_bft), 64'd0);
    chk("rst_vld", 64'(vld_out), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_ack", 64'(ack_out), 64'd0);

    // Two data packets to inputs 0 and 3
    send_pkt(2, 0, 32'hA5);
    exp_in[0].push_back(32'hA5);
    chk("t1_vld_first", 64'(vld_out), 64'b0001);
    send_pkt(5, 0, 32'h3C);
    exp_in[3].push_back(32'h3C);
    chk("t1_vld_both", 64'(vld_out), 64'b1001);
    ack_in = 4'b1001;
    cycle();
    ack_in = '0;
    chk("t1_vld_clear", 64'(vld_out), 64'd0);

    // Ports beyond the last input are dropped silently
    send_pkt(6, 0, 32'h11);
    send_pkt(15, 0, 32'h22);
    cycle();
    chk("t1_oob_vld", 64'(vld_out), 64'd0);
    chk("t1_oob_ovf", 64'(ovf), 64'd0);

    // Overfill input 0 without acks
    for (int k = 1; k <= 17; k++) begin
      send_pkt(2, 0, PAY'(k));
      if (k <= 16) exp_in[0].push_back(PAY'(k));
    end
    chk("t2_ovf_set", 64'(ovf), 64'b0001);
    drain(0, "t2_drain");
    chk("t2_ovf_sticky", 64'(ovf), 64'b0001);

    // Same stream with ack held high never overflows
    do_reset();
    ack_in[0] = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      send_pkt(2, 0, PAY'(100 + k));
      exp_in[0].push_back(PAY'(100 + k));
    end
    drain(0, "t2b_drain");
    chk("t2b_ovf", 64'(ovf), 64'd0);

    // Exactly full, then push and pop in the same cycle
    for (int k = 1; k <= 16; k++) begin
      send_pkt(2, 0, PAY'(200 + k));
      exp_in[0].push_back(PAY'(200 + k));
    end
    chk("t2c_full_no_ovf", 64'(ovf), 64'd0);
    ack_in[0] = 1'b1;
    send_pkt(2, 0, PAY'(217));
    exp_in[0].push_back(PAY'(217));
    chk("t2c_push_pop_full", 64'(ovf), 64'd0);
    drain(0, "t2c_drain");

    // Route config takes effect for the very next launch
    send_pkt(0, 1, 32'h93);
    base[1] = 32'hDEADBEEF;
    exp_bft.push_back(mk(9, 3, 1, 32'hDEADBEEF));
    words_left[1] = 1;
    for (int n = 0; n < 10 && exp_bft.size() != 0; n++) cycle();
    chk("t3_sb_empty", 64'(exp_bft.size()), 64'd0);
    cycle();
    chk("t3_dout_idle", 64'(dout_bft[PKT-1]), 64'd0);

    // Round-robin over three outputs with a resend stall in the middle
    do_reset();
    for (int i = 0; i < NO; i++) begin
      base[i] = 32'hC000_0000 | (PAY'(i) << 16);
      cnt[i] = 0;
    end
    for (int k = 0; k < 6; k++) begin
      exp_bft.push_back(mk(0, 0, ord4[k], base[ord4[k]] + PAY'(cnt[ord4[k]])));
      cnt[ord4[k]]++;
    end
    for (int i = 0; i < NO; i++) words_left[i] = 3;
    cycle();
    for (int c = 0; c < 10; c++) begin
      resend = (c == 2);
      if (c == 2) begin
        #1;
        chk("t4_resend_ack", 64'(ack_out), 64'd0);
        snap = dout_bft;
        cycle();
        chk("t4_resend_hold", 64'(dout_bft), 64'(snap));
      end else begin
        cycle();
      end
    end
    resend = 1'b0;
    chk("t4_credit_block", 64'(ack_out), 64'd0);
    chk("t4_sb_empty", 64'(exp_bft.size()), 64'd0);

    // Credit exhaustion on output 0 and recovery by a credit packet
    do_reset();
    send_pkt(1, 1, 32'd5);
    send_pkt(1, 2, 32'd5);
    for (int i = 0; i < NO; i++) cnt[i] = 0;
    for (int k = 0; k < 10; k++) begin
      exp_bft.push_back(mk(0, 0, ord5[k], base[ord5[k]] + PAY'(cnt[ord5[k]])));
      cnt[ord5[k]]++;
    end
    words_left[0] = 8;
    words_left[1] = 4;
    words_left[2] = 4;
    repeat (16) cycle();
    chk("t5_out0_blocked", 64'(ack_out), 64'd0);
    chk("t5_sb_phase1", 64'(exp_bft.size()), 64'd0);
    for (int n = 2; n < 7; n++) exp_bft.push_back(mk(0, 0, 0, base[0] + PAY'(n)));
    send_pkt(1, 0, 32'd5);
    repeat (12) cycle();
    chk("t5_exact_five", 64'(ack_out), 64'd0);
    chk("t5_sb_phase2", 64'(exp_bft.size()), 64'd0);

    // Reset in the middle of traffic
    do_reset();
    for (int k = 0; k < 8; k++) send_pkt(2, 0, PAY'(300 + k));
    for (int k = 0; k < 17; k++) send_pkt(5, 0, PAY'(400 + k));
    chk("t6_ovf_pre", 64'(ovf), 64'b1000);
    chk("t6_vld_pre", 64'(vld_out), 64'b1001);
    base[0] = 32'h7700_0000;
    exp_bft.push_back(mk(0, 0, 0, 32'h7700_0000));
    words_left[0] = 1;
    cycle();
    resend = 1'b1;
    cycle();
    chk("t6_held", 64'(dout_bft), 64'(mk(0, 0, 0, 32'h7700_0000)));
    reset = 1'b1;
    cycle();
    chk("t6_rst_dout", 64'(dout_bft), 64'd0);
    chk("t6_rst_vld", 64'(vld_out), 64'd0);
    chk("t6_rst_ovf", 64'(ovf), 64'd0);
    for (int i = 0; i < NI; i++) exp_in[i].delete();
    reset = 1'b0;
    resend = 1'b0;
    cycle();
    chk("t6_post_vld", 64'(vld_out), 64'd0);
    chk("t6_sb_empty", 64'(exp_bft.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/leaf_stream_router.md
Name: leaf_stream_router

Overview:
- Parametrised successor to the fixed per-page leaf interface.
- Sits between one BFT leaf link and a user kernel with NUM_IN_PORTS input streams and NUM_OUT_PORTS output streams.
- Demultiplexes inbound BFT packets into per-port FIFOs and accepts runtime route configuration.
- Applies credit-based flow control per output, then merges user outputs round-robin into the outbound BFT link.

Parameters:
- PAYLOAD_BITS, 32, payload width.
- NUM_LEAF_BITS, 5, destination leaf field width.
- NUM_PORT_BITS, 4, destination port field width.
- NUM_ADDR_BITS, 7, address field width; carries the source output index in credit packets.
- PACKET_BITS, 1+NUM_LEAF_BITS+NUM_PORT_BITS+NUM_ADDR_BITS+PAYLOAD_BITS (=49), packet width.
- NUM_IN_PORTS, 4, user input streams, 1..(2^NUM_PORT_BITS-2).
- NUM_OUT_PORTS, 3, user output streams, 1..2^NUM_ADDR_BITS.
- FIFO_DEPTH, 16, per-input FIFO depth, power of two.
- INIT_CREDITS, 64, reset credit count per output.

Ports:
- clk  in  1  sole clock
- reset  in  1  synchronous, active-high
- din_leaf_bft2interface  in  PACKET_BITS  inbound packet; bit[PACKET_BITS-1] = valid
- dout_leaf_interface2bft  out  PACKET_BITS  outbound packet, registered
- resend  in  1  downstream rejected last packet; hold output
- dout_leaf_interface2user  out  NUM_IN_PORTS*PAYLOAD_BITS  per-input data, port i at slice i
- vld_interface2user  out  NUM_IN_PORTS  FIFO non-empty
- ack_user2interface  in  NUM_IN_PORTS  user pop
- din_leaf_user2interface  in  NUM_OUT_PORTS*PAYLOAD_BITS  per-output data
- vld_user2interface  in  NUM_OUT_PORTS  user data valid
- ack_interface2user  out  NUM_OUT_PORTS  one-hot grant, combinational
- overflow  out  NUM_IN_PORTS  sticky drop flag per input

Behaviour:
- Packet layout, MSB to LSB: valid, leaf, port, addr, payload.
- Reset (synchronous, active-high, clk):
  - dout = 0, all FIFOs empty, vld = 0, overflow = 0.
  - Credits = INIT_CREDITS; route table = 0; round-robin pointer = 0.
- Reset mid-operation discards all FIFO contents and any held packet.

Inbound decode, one packet per cycle when valid=1:
- port 0 (config): payload[NUM_LEAF_BITS+NUM_PORT_BITS-1:0] = {leaf, port} is written to route[addr].
  - If addr >= NUM_OUT_PORTS, the packet is ignored.
  - The write takes effect for packets launched the following cycle.
- port 1 (credit return): credit[addr] += payload, saturating at 2^(clog2(INIT_CREDITS)+8)-1.
  - If addr >= NUM_OUT_PORTS, the packet is ignored.
- port p >= 2: input i = p-2; payload is pushed into FIFO i.
  - If FIFO i is full and not popped this cycle: the packet is dropped and overflow[i] is set.
  - If i >= NUM_IN_PORTS: the packet is dropped and no flag is set.

Input FIFOs:
- vld[i] = !empty; data = head.
- Pop on vld[i] & ack[i].
- Push to an empty FIFO is visible the next cycle (1-cycle latency).
- Simultaneous push and pop on a full FIFO is legal: count unchanged, no drop.
- Pointers wrap modulo FIFO_DEPTH.

Outbound path:
- Output i is eligible when vld_user2interface[i] & credit[i] != 0.
- Each cycle with resend=0, the arbiter grants the first eligible i at or after rr_ptr, wrapping.
- The grant raises ack_interface2user[i] for that cycle only.
- The next cycle, dout = {1, route[i].leaf, route[i].port, i[NUM_ADDR_BITS-1:0], payload}.
- On a grant: credit[i] decrements and rr_ptr = i+1 mod NUM_OUT_PORTS.
- With no grant, dout valid bit = 0 and the other fields are don't-care (driven 0).
- resend=1: dout holds its value, no grant, ack = 0, credits and rr_ptr unchanged.
- Same-cycle credit return and send on one output: net = credit + payload - 1.
- credit == 0 blocks the output; the arbiter skips it without stalling the others.

Test Plan:
- Reset, then data packets to port 2 and port 5 (payloads 0xA5, 0x3C) → vld_interface2user = 4'b1001 one cycle later; heads are 0xA5 and 0x3C; each ack clears its vld.
- 17 packets to port 2 with FIFO_DEPTH=16 and no ack → 16 stored; overflow[0] = 1; popped order is 1..16. Repeat with ack held high → no overflow.
- Config addr=1 payload {leaf 9, port 3}; user output 1 sends 0xDEADBEEF → dout valid with leaf=9, port=3, addr=1, payload 0xDEADBEEF.
- All three outputs valid continuously → grants 0,1,2,0,1,2; resend=1 mid-sequence holds dout and freezes grants for that cycle.
- INIT_CREDITS=2, output 0 sends 2 words → third word blocked while outputs 1 and 2 proceed; credit packet addr=0 payload 5 → output 0 resumes and sends exactly 5 more.
- Assert reset with FIFOs half full and a packet held under resend → next cycle all vld = 0, dout = 0, overflow = 0.
